// File: rtl/cas_pkg.sv
// Shared types and defaults for the compare-and-swap output stage.
// The entry struct is sized by the package defaults, so any block that
// stores cas_entry_t must be built with ADDRW=ADDRW_DEF and WL=WL_DEF.
package cas_pkg;

    localparam int ADDRW_DEF = 10;
    localparam int WL_DEF    = 32;

    typedef struct packed {
        logic [ADDRW_DEF-1:0] index;
        logic [WL_DEF-1:0]    value;
    } cas_entry_t;

    // Number of entries presented in one cycle (0, 1 or 2).
    function automatic logic [1:0] entry_count(input logic v1, input logic v2);
        return {1'b0, v1} + {1'b0, v2};
    endfunction

endpackage

// File: rtl/cas_order_chk.sv
// Sticky ordering monitor for the index stream entering the pair FIFO.
// Flags any accepted index that is not strictly greater than the index
// accepted just before it, both within a pair and across writes.
module cas_order_chk
    import cas_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             valid1,
    input  logic             valid2,
    input  logic [ADDRW-1:0] index1,
    input  logic [ADDRW-1:0] index2,
    output logic             order_err
);

    logic             seen;
    logic [ADDRW-1:0] last_index;
    logic             any_wr;
    logic [ADDRW-1:0] first_index;
    logic [ADDRW-1:0] final_index;
    logic             bad_cross;
    logic             bad_pair;

    // Pick the first and last index of this write and evaluate both orderings.
    always_comb begin
        any_wr      = wr_en && (valid1 || valid2);
        first_index = valid1 ? index1 : index2;
        final_index = valid2 ? index2 : index1;
        bad_cross   = any_wr && seen && (first_index <= last_index);
        bad_pair    = wr_en && valid1 && valid2 && (index2 <= index1);
    end

    // Remember the most recent index and hold the error until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen       <= 1'b0;
            last_index <= '0;
            order_err  <= 1'b0;
        end else begin
            if (any_wr) begin
                seen       <= 1'b1;
                last_index <= final_index;
            end
            if (bad_cross || bad_pair) begin
                order_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cas_pair_fifo.sv
// Two-in / one-out FIFO behind the compare-and-swap merge stage.
// Upstream may present up to two sorted entries per cycle; they are stored
// slot 1 then slot 2 and drained one per cycle on a valid/ready port.
// ena_o throttles upstream early enough that a full pair always fits.
// Optional build macro: CAS_PAIR_FIFO_ORDER_CHK_EN adds the sticky
// order_err output driven by cas_order_chk.
module cas_pair_fifo
    import cas_pkg::*;
#(
    parameter int ADDRW = ADDRW_DEF,
    parameter int WL    = WL_DEF,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
)
(
    input  logic             clk,
    input  logic             rst,
    output logic             ena_o,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic [ADDRW-1:0] in_index1,
    input  logic [ADDRW-1:0] in_index2,
    input  logic [WL-1:0]    in_value1,
    input  logic [WL-1:0]    in_value2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADDRW-1:0] out_index,
    output logic [WL-1:0]    out_value,
`ifdef CAS_PAIR_FIFO_ORDER_CHK_EN
    output logic             order_err,
`endif
    output logic [AW:0]      count_o
);

    cas_entry_t       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             wr_en;
    logic             rd;
    logic [1:0]       n_wr;
    logic [AW-1:0]    wr_addr1;
    logic [AW:0]      count_next;
    cas_entry_t       entry1;
    cas_entry_t       entry2;
    cas_entry_t       head;

    // Backpressure depends only on registered occupancy, never on inputs.
    always_comb begin
        ena_o = !rst && (count <= (AW+1)'(DEPTH - 2));
    end

    // Write/read qualification, pointer arithmetic and occupancy update.
    always_comb begin
        wr_en         = ena_o;
        n_wr          = wr_en ? entry_count(in_valid1, in_valid2) : 2'd0;
        wr_addr1      = wr_ptr + AW'(1);
        entry1.index  = in_index1;
        entry1.value  = in_value1;
        entry2.index  = in_index2;
        entry2.value  = in_value2;
        out_valid     = (count != '0);
        rd            = out_valid && out_ready;
        count_next    = count + (AW+1)'(n_wr) - (AW+1)'(rd);
    end

    // Two write ports: the first valid slot lands at wr_ptr, slot 2 of a
    // full pair at wr_ptr+1 (wrapping naturally since DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (in_valid1) begin
                mem[wr_ptr] <= entry1;
            end else if (in_valid2) begin
                mem[wr_ptr] <= entry2;
            end
            if (in_valid1 && in_valid2) begin
                mem[wr_addr1] <= entry2;
            end
        end
    end

    // Pointer and occupancy registers; reset drops everything stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_wr);
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Head is read straight from storage; no write-to-read bypass.
    always_comb begin
        head      = mem[rd_ptr];
        out_index = head.index;
        out_value = head.value;
        count_o   = count;
    end

`ifdef CAS_PAIR_FIFO_ORDER_CHK_EN
    cas_order_chk #(
        .ADDRW (ADDRW)
    ) u_order_chk (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .valid1    (in_valid1),
        .valid2    (in_valid2),
        .index1    (in_index1),
        .index2    (in_index2),
        .order_err (order_err)
    );
`endif

endmodule

// File: tb/tb_cas_pair_fifo.sv
// Bench for cas_pair_fifo: directed scenarios plus random traffic, all
// checked against a queue model of the FIFO kept in the bench.
module tb_cas_pair_fifo;
    import cas_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena_o;
    logic        in_valid1 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic [9:0]  in_index1 = '0;
    logic [9:0]  in_index2 = '0;
    logic [31:0] in_value1 = '0;
    logic [31:0] in_value2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_index;
    logic [31:0] out_value;
    logic [AW:0] count_o;
`ifdef CAS_PAIR_FIFO_ORDER_CHK_EN
    logic        order_err;
`endif

    cas_pair_fifo #(.ADDRW(10), .WL(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena_o     (ena_o),
        .in_valid1 (in_valid1),
        .in_valid2 (in_valid2),
        .in_index1 (in_index1),
        .in_index2 (in_index2),
        .in_value1 (in_value1),
        .in_value2 (in_value2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value),
`ifdef CAS_PAIR_FIFO_ORDER_CHK_EN
        .order_err (order_err),
`endif
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    cas_entry_t  q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_err  = 1'b0;
    bit          m_seen = 1'b0;
    logic [9:0]  m_last = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input logic [9:0] idx, input logic [31:0] val);
        cas_entry_t e;
        e.index = idx;
        e.value = val;
        if (m_seen && idx <= m_last) m_err = 1'b1;
        m_seen = 1'b1;
        m_last = idx;
        q.push_back(e);
    endfunction

    // One clock: drive at negedge, compare outputs against the model, then
    // advance the model with what the DUT saw at the posedge.
    task automatic cyc(input logic r, input logic v1, input logic v2,
                       input logic [9:0] i1, input logic [9:0] i2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic rdy);
        bit en;
        @(negedge clk);
        rst = r; in_valid1 = v1; in_valid2 = v2;
        in_index1 = i1; in_index2 = i2; in_value1 = d1; in_value2 = d2;
        out_ready = rdy;
        #1;
        en = (q.size() <= DEPTH - 2);
        chk("ena_o", ena_o, !r && en);
        chk("out_valid", out_valid, q.size() != 0);
        chk("count_o", count_o, q.size());
        chk("count_bound", count_o <= DEPTH, 1'b1);
        if (q.size() != 0) begin
            chk("out_index", out_index, q[0].index);
            chk("out_value", out_value, q[0].value);
        end
`ifdef CAS_PAIR_FIFO_ORDER_CHK_EN
        chk("order_err", order_err, m_err);
`endif
        @(posedge clk);
        if (r) begin
            q.delete();
            m_err  = 1'b0;
            m_seen = 1'b0;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (en) begin
                if (v1) model_push(i1, d1);
                if (v2) model_push(i2, d2);
            end
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, rdy);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        // bring registers out of X before the model-based checks start
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        idle(1'b0);
        #1;
        chk("rst_ena", ena_o, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", count_o, 0);

        // pair (3,1.0)+(7,2.0) held, then drained
        cyc(1'b0, 1'b1, 1'b1, 10'd3, 10'd7, 32'h3f80_0000, 32'h4000_0000, 1'b0);
        #1;
        chk("pair_count", count_o, 2);
        chk("pair_head_idx", out_index, 10'd3);
        chk("pair_head_val", out_value, 32'h3f80_0000);
        idle(1'b1);
        #1;
        chk("pair_second_idx", out_index, 10'd7);
        chk("pair_second_val", out_value, 32'h4000_0000);
        idle(1'b1);
        #1;
        chk("pair_empty", out_valid, 1'b0);

        // slot-1-only then slot-2-only
        cyc(1'b0, 1'b1, 1'b0, 10'd5, 10'd0, 32'h11, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 10'd0, 10'd9, 32'h0, 32'h22, 1'b1);
        #1;
        chk("single_idx9", out_index, 10'd9);
        idle(1'b1);
        idle(1'b1);
        #1;
        chk("single_drained", count_o, 0);

        // fill with pairs while stalled; later pairs are held and must not duplicate
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 10'(2*i + 1), 10'(2*i + 2),
                32'(100 + i), 32'(200 + i), 1'b0);
        end
        #1;
        chk("fill_count", count_o, DEPTH);
        chk("fill_ena", ena_o, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        #1;
        chk("fill_drained", count_o, 0);

        // wrap: move pointers to 15, then a pair straddles the end of storage
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 10'(i + 1), 10'd0, 32'(i), 32'h0, 1'b1);
        end
        cyc(1'b0, 1'b1, 1'b1, 10'd20, 10'd21, 32'haaaa_5555, 32'h5555_aaaa, 1'b1);
        #1;
        chk("wrap_first", out_index, 10'd20);
        idle(1'b1);
        #1;
        chk("wrap_second", out_index, 10'd21);
        chk("wrap_second_val", out_value, 32'h5555_aaaa);
        idle(1'b1);

        // reset while holding six entries
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 10'(2*i + 1), 10'(2*i + 2), 32'(i), 32'(i), 1'b0);
        end
        #1;
        chk("pre_rst_count", count_o, 6);
        do_reset();
        #1;
        chk("post_rst_count", count_o, 0);
        chk("post_rst_valid", out_valid, 1'b0);

`ifdef CAS_PAIR_FIFO_ORDER_CHK_EN
        cyc(1'b0, 1'b1, 1'b0, 10'd8, 10'd0, 32'h1, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 10'd8, 10'd0, 32'h2, 32'h0, 1'b0);
        #1;
        chk("order_dup8", order_err, 1'b1);
        idle(1'b1);
        #1;
        chk("order_sticky", order_err, 1'b1);
        do_reset();
        #1;
        chk("order_cleared", order_err, 1'b0);
`endif

        // random traffic with occasional resets
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(99) == 0,
                1'($urandom_range(1)), 1'($urandom_range(1)),
                10'($urandom), 10'($urandom), $urandom, $urandom,
                $urandom_range(99) < 45);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
